// File: rtl/wb_pkg.sv
// Shared types for the write-back arbiter: register address, data word and result payload.
package wb_pkg;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] data_t;

    typedef struct packed {
        reg_addr_t rd;
        data_t     data;
    } wb_result_t;
endpackage

// File: rtl/wb_skid_buffer.sv
// One-entry skid buffer: an incoming result passes straight through when taken,
// otherwise it is parked here until the arbiter takes it.
module wb_skid_buffer
    import wb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_valid,
    output logic       o_ready,
    input  wb_result_t i_data,
    output logic       o_have,
    output wb_result_t o_head,
    input  logic       i_take
);
    logic       r_full;
    wb_result_t r_data;
    logic       w_ready;

    // A parked entry leaves at the edge that writes it, so it is never on the
    // write port while still held here; input is blocked for as long as it is held.
    assign w_ready = rst && !r_full;
    assign o_ready = w_ready;
    assign o_have  = r_full || (i_valid && w_ready);
    assign o_head  = r_full ? r_data : i_data;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_full <= 1'b0;
            r_data <= '0;
        end else if (r_full) begin
            if (i_take) begin
                r_full <= 1'b0;
            end
        end else if (i_valid && w_ready && !i_take) begin
            r_full <= 1'b1;
            r_data <= i_data;
        end
    end
endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges ALU and load results onto one register-file write port
// and tracks pending destinations for decode hazards. Optional bypass: WB_FORWARD_EN.
module wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [ADDR_W-1:0] mem_rd,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_rd,
    input  logic [ADDR_W-1:0] chk_rs1,
    input  logic [ADDR_W-1:0] chk_rs2,
    output logic              hazard,
    output logic              we3,
    output logic [ADDR_W-1:0] ad3,
    output logic [DATA_W-1:0] wd3,
    output logic              fwd1_hit,
    output logic              fwd2_hit,
    output logic [DATA_W-1:0] fwd1_data,
    output logic [DATA_W-1:0] fwd2_data
);
    import wb_pkg::*;

    localparam int NREGS = 2 ** ADDR_W;

    wb_result_t        w_alu_in, w_mem_in, w_alu_head, w_mem_head, w_win;
    logic              w_alu_have, w_mem_have, w_alu_want, w_mem_want;
    logic              w_gnt_alu, w_gnt_mem, w_take_alu, w_take_mem, w_conflict;
    logic              r_rr_mem;
    logic              r_we3;
    logic [ADDR_W-1:0] r_ad3;
    logic [DATA_W-1:0] r_wd3;
    logic [NREGS-1:0]  r_pending, w_set, w_clr;
    logic              w_src1, w_src2;

    assign w_alu_in = '{rd: alu_rd, data: alu_data};
    assign w_mem_in = '{rd: mem_rd, data: mem_data};

    wb_skid_buffer u_alu_buf (
        .clk     (clk),
        .rst     (rst),
        .i_valid (alu_valid),
        .o_ready (alu_ready),
        .i_data  (w_alu_in),
        .o_have  (w_alu_have),
        .o_head  (w_alu_head),
        .i_take  (w_take_alu)
    );

    wb_skid_buffer u_mem_buf (
        .clk     (clk),
        .rst     (rst),
        .i_valid (mem_valid),
        .o_ready (mem_ready),
        .i_data  (w_mem_in),
        .o_have  (w_mem_have),
        .o_head  (w_mem_head),
        .i_take  (w_take_mem)
    );

    // x0 results never compete for the slot; they are taken and dropped on arrival.
    always_comb begin
        w_alu_want = w_alu_have && (w_alu_head.rd != '0);
        w_mem_want = w_mem_have && (w_mem_head.rd != '0);
        w_conflict = w_alu_want && w_mem_want;
        w_gnt_mem  = w_mem_want && (!w_alu_want || r_rr_mem);
        w_gnt_alu  = w_alu_want && !w_gnt_mem;
        w_take_alu = w_alu_have && ((w_alu_head.rd == '0) || w_gnt_alu);
        w_take_mem = w_mem_have && ((w_mem_head.rd == '0) || w_gnt_mem);
        w_win      = w_gnt_mem ? w_mem_head : w_alu_head;
    end

    // The pointer only moves on a real conflict, so the first conflict after reset goes to mem.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_we3    <= 1'b0;
            r_ad3    <= '0;
            r_wd3    <= '0;
            r_rr_mem <= 1'b1;
        end else begin
            r_we3 <= w_gnt_alu || w_gnt_mem;
            if (w_gnt_alu || w_gnt_mem) begin
                r_ad3 <= w_win.rd;
                r_wd3 <= w_win.data;
            end
            if (w_conflict) begin
                r_rr_mem <= !w_gnt_mem;
            end
        end
    end

    assign we3 = r_we3;
    assign ad3 = r_ad3;
    assign wd3 = r_wd3;

    always_comb begin
        w_set = '0;
        w_clr = '0;
        if (iss_valid && (iss_rd != '0)) begin
            w_set[iss_rd] = 1'b1;
        end
        if (r_we3) begin
            w_clr[r_ad3] = 1'b1;
        end
    end

    // Set is applied after clear so a same-cycle issue keeps the register pending.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clr) | w_set;
        end
    end

`ifdef WB_FORWARD_EN
    assign fwd1_hit  = r_we3 && (r_ad3 != '0) && (r_ad3 == chk_rs1);
    assign fwd2_hit  = r_we3 && (r_ad3 != '0) && (r_ad3 == chk_rs2);
    assign fwd1_data = r_wd3;
    assign fwd2_data = r_wd3;
`else
    assign fwd1_hit  = 1'b0;
    assign fwd2_hit  = 1'b0;
    assign fwd1_data = '0;
    assign fwd2_data = '0;
`endif

    assign w_src1 = r_pending[chk_rs1] && !fwd1_hit;
    assign w_src2 = r_pending[chk_rs2] && !fwd2_hit;
    assign hazard = rst && (w_src1 || w_src2 || (iss_valid && r_pending[iss_rd]));
endmodule
